// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and constants for the key debouncer.
//   lane_state_e        - per-lane debounce FSM state
//   DEF_*               - default timing parameters (50 MHz system clock)
//   DB_CNT_W/RPT_CNT_W  - counter widths sized for the largest legal parameters
//   db_sat_inc/rpt_sat_inc - saturating increments for the two counters
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } lane_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms at 50 MHz
  localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz

  localparam int DB_CNT_MAX  = 16777215;          // 2^24-1
  localparam int RPT_CNT_MAX = 67108863;          // 2^26-1
  localparam int DB_CNT_W    = $clog2(DB_CNT_MAX + 1);
  localparam int RPT_CNT_W   = $clog2(RPT_CNT_MAX + 1);

  function automatic logic [DB_CNT_W-1:0] db_sat_inc(input logic [DB_CNT_W-1:0] v);
    if (v == {DB_CNT_W{1'b1}}) begin
      db_sat_inc = v;
    end else begin
      db_sat_inc = v + DB_CNT_W'(1);
    end
  endfunction

  function automatic logic [RPT_CNT_W-1:0] rpt_sat_inc(input logic [RPT_CNT_W-1:0] v);
    if (v == {RPT_CNT_W{1'b1}}) begin
      rpt_sat_inc = v;
    end else begin
      rpt_sat_inc = v + RPT_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// key_debounce_lane: one push-button lane.
//   clk_0         - system clock
//   reset         - synchronous active-high reset
//   key_raw_n     - raw asynchronous active-low pin
//   key_level_n   - debounced active-low level (registered)
//   press_pulse   - one-cycle strobe on accepted press
//   release_pulse - one-cycle strobe on accepted release
//   repeat_pulse  - one-cycle auto-repeat strobe while held
module key_debounce_lane
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_0,
  input  logic reset,
  input  logic key_raw_n,
  output logic key_level_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [DB_CNT_W-1:0]  DB_TARGET  = DB_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [RPT_CNT_W-1:0] RPT_DELAY  = RPT_CNT_W'(REPEAT_DELAY);
  localparam logic [RPT_CNT_W-1:0] RPT_PERIOD = RPT_CNT_W'(REPEAT_PERIOD);
  localparam bit                   RPT_EN     = (REPEAT_DELAY != 0);

  logic                 sync_meta_r, sync_r;
  lane_state_e          state_r, state_s;
  logic [DB_CNT_W-1:0]  db_cnt_r, db_cnt_s, db_inc_s;
  logic [RPT_CNT_W-1:0] rpt_cnt_r, rpt_cnt_s, rpt_inc_s, rpt_tgt_s;
  logic                 rpt_phase_r, rpt_phase_s;  // 0: waiting initial delay, 1: periodic
  logic                 level_r, level_s;
  logic                 press_r, press_s;
  logic                 release_r, release_s;
  logic                 repeat_r, repeat_s;

  // Two-flop synchronizer; idles high (released) so reset never fakes a press.
  always_ff @(posedge clk_0) begin
    if (reset) begin
      sync_meta_r <= 1'b1;
      sync_r      <= 1'b1;
    end else begin
      sync_meta_r <= key_raw_n;
      sync_r      <= sync_meta_r;
    end
  end

  // Next-state, counter and strobe logic for the debounce FSM.
  always_comb begin
    state_s     = state_r;
    db_cnt_s    = db_cnt_r;
    rpt_cnt_s   = rpt_cnt_r;
    rpt_phase_s = rpt_phase_r;
    press_s     = 1'b0;
    release_s   = 1'b0;
    repeat_s    = 1'b0;
    db_inc_s    = db_sat_inc(db_cnt_r);
    rpt_inc_s   = rpt_sat_inc(rpt_cnt_r);
    rpt_tgt_s   = rpt_phase_r ? RPT_PERIOD : RPT_DELAY;

    case (state_r)
      ST_RELEASED: begin
        rpt_cnt_s   = '0;
        rpt_phase_s = 1'b0;
        // db_cnt is 0 here, so db_inc_s == 1; covers DEBOUNCE_CYCLES == 1.
        if (!sync_r) begin
          if (db_inc_s >= DB_TARGET) begin
            state_s  = ST_PRESSED;
            press_s  = 1'b1;
            db_cnt_s = '0;
          end else begin
            state_s  = ST_PRESS_WAIT;
            db_cnt_s = db_inc_s;
          end
        end else begin
          db_cnt_s = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (sync_r) begin
          state_s  = ST_RELEASED;
          db_cnt_s = '0;
        end else if (db_inc_s >= DB_TARGET) begin
          state_s     = ST_PRESSED;
          press_s     = 1'b1;
          db_cnt_s    = '0;
          rpt_cnt_s   = '0;
          rpt_phase_s = 1'b0;
        end else begin
          db_cnt_s = db_inc_s;
        end
      end

      ST_PRESSED: begin
        if (sync_r && (db_inc_s >= DB_TARGET)) begin
          // Single-sample debounce: release immediately, suppress any repeat.
          state_s     = ST_RELEASED;
          release_s   = 1'b1;
          db_cnt_s    = '0;
          rpt_cnt_s   = '0;
          rpt_phase_s = 1'b0;
        end else begin
          // The repeat timer advances on every cycle spent in PRESSED.
          if (RPT_EN) begin
            if (rpt_inc_s >= rpt_tgt_s) begin
              repeat_s    = 1'b1;
              rpt_cnt_s   = '0;
              rpt_phase_s = 1'b1;
            end else begin
              rpt_cnt_s = rpt_inc_s;
            end
          end else begin
            rpt_cnt_s = '0;
          end
          if (sync_r) begin
            state_s  = ST_RELEASE_WAIT;
            db_cnt_s = db_inc_s;
          end else begin
            db_cnt_s = '0;
          end
        end
      end

      ST_RELEASE_WAIT: begin
        // Repeat timer holds here so a glitch only delays the cadence.
        if (!sync_r) begin
          state_s  = ST_PRESSED;
          db_cnt_s = '0;
        end else if (db_inc_s >= DB_TARGET) begin
          state_s     = ST_RELEASED;
          release_s   = 1'b1;
          db_cnt_s    = '0;
          rpt_cnt_s   = '0;
          rpt_phase_s = 1'b0;
        end else begin
          db_cnt_s = db_inc_s;
        end
      end

      default: begin
        state_s     = ST_RELEASED;
        db_cnt_s    = '0;
        rpt_cnt_s   = '0;
        rpt_phase_s = 1'b0;
      end
    endcase

    level_s = ~((state_s == ST_PRESSED) || (state_s == ST_RELEASE_WAIT));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_0) begin
    if (reset) begin
      state_r     <= ST_RELEASED;
      db_cnt_r    <= '0;
      rpt_cnt_r   <= '0;
      rpt_phase_r <= 1'b0;
      level_r     <= 1'b1;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      repeat_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      db_cnt_r    <= db_cnt_s;
      rpt_cnt_r   <= rpt_cnt_s;
      rpt_phase_r <= rpt_phase_s;
      level_r     <= level_s;
      press_r     <= press_s;
      release_r   <= release_s;
      repeat_r    <= repeat_s;
    end
  end

  assign key_level_n   = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: NUM_KEYS independent debounced push-button lanes.
//   clk_0         - system clock
//   reset         - synchronous active-high reset
//   key_raw_n     - raw asynchronous active-low pins
//   key_level_n   - debounced active-low levels (feeds in_port_to_the_keys)
//   press_pulse   - per-lane one-cycle press strobes
//   release_pulse - per-lane one-cycle release strobes
//   repeat_pulse  - per-lane auto-repeat strobes
//   any_press     - OR of press_pulse
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk_0,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] key_level_n,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                any_press
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_lane (
      .clk_0         (clk_0),
      .reset         (reset),
      .key_raw_n     (key_raw_n[i]),
      .key_level_n   (key_level_n[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  // OR of registered strobes, so it lines up with press_pulse.
  assign any_press = |press_pulse;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NUM_KEYS, default 3: number of independent key lanes, one per KEY[3:1] push-button.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable samples (20 ms at 50 MHz) required to accept a level change; legal range 1..2^24-1.
REQ-003 Parameter REPEAT_DELAY, default 25000000: cycles in PRESSED before the first repeat_pulse; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses; legal range 1..2^26-1.
REQ-005 clk_0  input  1  system clock; one clock for the whole block.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key_raw_n  input  NUM_KEYS  raw asynchronous active-low button pins.
REQ-008 key_level_n  output  NUM_KEYS  debounced active-low level; drives in_port_to_the_keys.
REQ-009 press_pulse  output  NUM_KEYS  one-cycle strobe on accepted press.
REQ-010 release_pulse  output  NUM_KEYS  one-cycle strobe on accepted release.
REQ-011 repeat_pulse  output  NUM_KEYS  one-cycle auto-repeat strobe while held.
REQ-012 any_press  output  1  OR of press_pulse.

Function
REQ-013 Each key_raw_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each lane SHALL run the FSM RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; lanes are fully independent.
REQ-015 RELEASED: synced low -> PRESS_WAIT with count=1; else stay.
REQ-016 PRESS_WAIT: synced high -> RELEASED, count cleared, no pulse; count reaching DEBOUNCE_CYCLES consecutive lows -> PRESSED.
REQ-017 PRESSED: synced high -> RELEASE_WAIT with count=1; RELEASE_WAIT mirrors PRESS_WAIT, exiting to RELEASED on DEBOUNCE_CYCLES consecutive highs or back to PRESSED on any low, with no pulse in that case.
REQ-018 Latency: with E0 the first edge sampling key_raw_n low, press_pulse SHALL be high in exactly the cycle after edge E0+1+DEBOUNCE_CYCLES; release is symmetric.
REQ-019 key_level_n SHALL go low in the same cycle as press_pulse and high in the same cycle as release_pulse; all outputs are registered.
REQ-020 Repeat timer: cleared on entry to PRESSED from PRESS_WAIT; counts only in PRESSED; holds in RELEASE_WAIT; cleared in RELEASED.
REQ-021 repeat_pulse SHALL fire REPEAT_DELAY cycles after press_pulse, then every REPEAT_PERIOD cycles while the timer counts; never coincident with press_pulse or release_pulse.
REQ-022 Counters SHALL saturate, never wrap; widths come from $clog2 of the parameter maxima.
REQ-023 Simultaneous presses on several lanes SHALL yield same-cycle pulses on each lane.

Reset
REQ-024 reset SHALL force, on the next clk_0 edge: synchronizer flops=1, all FSMs RELEASED, counters 0, key_level_n all ones, all pulses and any_press 0.
REQ-025 Reset asserted mid-operation (any state) SHALL emit no release_pulse; a key still held afterward SHALL re-qualify with full REQ-018 latency.

Structure
REQ-026 Package key_debounce_pkg SHALL hold the lane-state enum and the default DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants.
REQ-027 One sub-module, key_debounce_lane (synchronizer, FSM, both counters), SHALL be instantiated NUM_KEYS times by generate; any_press is the only logic in the top-level block.

Verification (NUM_KEYS=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-028 Clean press: key_raw_n=3'b110 from E0, held -> press_pulse=3'b001 and any_press=1 for one cycle after E5; key_level_n=3'b110 from then on.
REQ-029 Bounce: lane 0 low 3 cycles, high 1, then low -> no pulse until 4 consecutive synced lows, then exactly one press_pulse.
REQ-030 Hold/repeat: hold lane 0 -> repeat_pulse 8 cycles after press_pulse, then at +11, +14 and so on; release -> release_pulse 5 edges after release, key_level_n[0]=1, repeats stop.
REQ-031 Release glitch: in PRESSED, raw high 2 cycles then low -> no release_pulse; key_level_n[0] stays 0; the repeat cadence continues, shifted by the 2 held cycles.
REQ-032 Simultaneous: lanes 1 and 2 low on the same edge -> press_pulse=3'b110 in a single cycle.
REQ-033 Reset mid-hold: 1-cycle reset while PRESSED -> key_level_n=3'b111 next cycle, no release_pulse; key still low -> new press_pulse 5 edges after reset deasserts.
